// File: rtl/alu_pkg.sv
// Shared ALU word types and the half-adder helper used by the segmented adder.
package alu_pkg;

    localparam int WORD_W = 32'd16;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic cout;
        logic ovf;
    } add_flags_t;

    // Returns {carry, sum} of two bits
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// Operand/result handshake bundle for seg_pipe_adder; the sub line exists only
// when SEG_PIPE_ADDER_SUB_EN is defined.
interface seg_pipe_adder_if #(
    parameter int WIDTH = alu_pkg::WORD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SEG_PIPE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, output a, output b, output cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, input out_valid, input sum, input cout, input ovf
    );

    modport slave (
        input  in_valid, input a, input b, input cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, output out_valid, output sum, output cout, output ovf
    );
endinterface

// File: rtl/seg_add.sv
// Combinational SEG_W-bit ripple adder; each bit is a full-adder cell made of two half adders.
module seg_add
    import alu_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             ci,
    output logic [SEG_W-1:0] s_seg,
    output logic             co,
    output logic             c_msb
);

    // Ripple the carry through the segment, keeping the carry into the top bit
    always_comb begin
        logic [SEG_W:0] carry_s;
        logic [1:0]     h1_s;
        logic [1:0]     h2_s;
        carry_s    = {(SEG_W+1){1'b0}};
        h1_s       = 2'b00;
        h2_s       = 2'b00;
        s_seg      = {SEG_W{1'b0}};
        carry_s[0] = ci;
        for (int i = 0; i < SEG_W; i++) begin
            h1_s           = half_add(a_seg[i], b_seg[i]);
            h2_s           = half_add(h1_s[0], carry_s[i]);
            s_seg[i]       = h2_s[0];
            carry_s[i+1]   = h1_s[1] | h2_s[1];
        end
        co    = carry_s[SEG_W];
        c_msb = carry_s[SEG_W-1];
    end

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined ripple adder resolving SEG_W bits per clock with a global valid/ready stall.
// Optional subtract mode: define SEG_PIPE_ADDER_SUB_EN to add the sub input.
module seg_pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SEG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_pipe_adder_if.slave   bus
);
    localparam int STAGES = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $fatal(1, "seg_pipe_adder: WIDTH must be a multiple of SEG_W");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b0_s;
    logic             c0_s;
    logic             ovf_r;

    // Whole pipeline advances unless a finished result is waiting on the consumer
    always_comb begin
        adv_s = !bus.out_valid || bus.out_ready;
    end

    assign bus.in_ready = adv_s;

`ifdef SEG_PIPE_ADDER_SUB_EN
    // Subtract is a + ~b + 1; cin is ignored in that mode
    always_comb begin
        if (bus.sub) begin
            b0_s = ~bus.b;
            c0_s = 1'b1;
        end else begin
            b0_s = bus.b;
            c0_s = bus.cin;
        end
    end
`else
    // Addition only: operands pass straight into stage 0
    always_comb begin
        b0_s = bus.b;
        c0_s = bus.cin;
    end
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int CW = WIDTH - k*SEG_W;

        logic [CW-1:0]          a_cur_s;
        logic [CW-1:0]          b_cur_s;
        logic                   ci_s;
        logic                   v_cur_s;
        logic [SEG_W-1:0]       seg_s;
        logic                   co_s;
        logic                   c_msb_s;
        logic [(k+1)*SEG_W-1:0] s_nxt_s;
        logic                   vld_r;
        logic                   c_r;
        logic [(k+1)*SEG_W-1:0] s_r;

        if (k == 0) begin : g_head
            assign a_cur_s = bus.a;
            assign b_cur_s = b0_s;
            assign ci_s    = c0_s;
            assign v_cur_s = bus.in_valid;
            assign s_nxt_s = seg_s;
        end else begin : g_body
            assign a_cur_s = g_stage[k-1].g_fwd.a_r;
            assign b_cur_s = g_stage[k-1].g_fwd.b_r;
            assign ci_s    = g_stage[k-1].c_r;
            assign v_cur_s = g_stage[k-1].vld_r;
            assign s_nxt_s = {seg_s, g_stage[k-1].s_r};
        end

        seg_add #(.SEG_W(SEG_W)) u_seg_add (
            .a_seg (a_cur_s[SEG_W-1:0]),
            .b_seg (b_cur_s[SEG_W-1:0]),
            .ci    (ci_s),
            .s_seg (seg_s),
            .co    (co_s),
            .c_msb (c_msb_s)
        );

        // Stage register: valid, carry and the low sum bits resolved so far
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                c_r   <= 1'b0;
                s_r   <= {((k+1)*SEG_W){1'b0}};
            end else if (adv_s) begin
                vld_r <= v_cur_s;
                c_r   <= co_s;
                s_r   <= s_nxt_s;
            end
        end

        if (k < STAGES-1) begin : g_fwd
            logic [CW-SEG_W-1:0] a_r;
            logic [CW-SEG_W-1:0] b_r;
            logic                unused_cmsb_s;

            assign unused_cmsb_s = c_msb_s;

            // Upper operand bits ride along until their segment is reached
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= {(CW-SEG_W){1'b0}};
                    b_r <= {(CW-SEG_W){1'b0}};
                end else if (adv_s) begin
                    a_r <= a_cur_s[CW-1:SEG_W];
                    b_r <= b_cur_s[CW-1:SEG_W];
                end
            end
        end
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            ovf_r <= g_stage[STAGES-1].co_s ^ g_stage[STAGES-1].c_msb_s;
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].vld_r;
    assign bus.sum       = g_stage[STAGES-1].s_r;
    assign bus.cout      = g_stage[STAGES-1].c_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: directed vector table, random scoreboard run, mid-flight reset.
module tb_seg_pipe_adder;
    localparam int W   = 16;
    localparam int SW  = 4;
    localparam int LAT = W / SW;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seg_pipe_adder_if #(.WIDTH(W)) bus ();

    seg_pipe_adder #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] bb;
        logic        c;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SEG_PIPE_ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub requested without subtract build");
`endif
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        drive(v.a, v.b, v.cin, v.sub);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT - 1);
        chk({tag, "_sum"},  bus.sum,  v.exp_sum);
        chk({tag, "_cout"}, bus.cout, v.exp_cout);
        chk({tag, "_ovf"},  bus.ovf,  v.exp_ovf);
        tick();
        chk({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [17:0] exp_q[$];
        logic [17:0] e;
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [15:0] held_sum;
        logic        held_cout, held_ovf, prev_stall;
        int          sent, got, budget, stale;
        vec_t        post;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);

        vecs.push_back('{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
`ifdef SEG_PIPE_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum",       bus.sum,       16'h0000);
        chk("rst_cout",      bus.cout,      1'b0);
        chk("rst_ovf",       bus.ovf,       1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Random back-to-back traffic with random backpressure
        sent = 0; got = 0; budget = 0; prev_stall = 1'b0;
        held_sum = 16'h0000; held_cout = 1'b0; held_ovf = 1'b0;
        while ((sent < 20 || exp_q.size() > 0) && budget < 600) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'b0;
`ifdef SEG_PIPE_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            drive(ra, rb, rc, rs);
            bus.in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            bus.out_ready = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("rand_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_sum",   bus.sum,  held_sum);
                chk("stall_cout",  bus.cout, held_cout);
                chk("stall_ovf",   bus.ovf,  held_ovf);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_result_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rand_sum",  bus.sum,  e[15:0]);
                    chk("rand_cout", bus.cout, e[16]);
                    chk("rand_ovf",  bus.ovf,  e[17]);
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_add(ra, rb, rc, rs));
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_sum   = bus.sum;
            held_cout  = bus.cout;
            held_ovf   = bus.ovf;
            tick();
            budget++;
        end
        bus.in_valid = 1'b0;
        chk("rand_received", got, 20);
        chk("rand_queue_empty", exp_q.size(), 0);
        repeat (LAT + 1) tick();

        // Fill the pipe, stall the head, then reset mid-flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            drive(16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre_reset_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_sum",   bus.sum,       16'h0000);
        chk("async_rst_cout",  bus.cout,      1'b0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (LAT + 4) begin
            tick();
            if (bus.out_valid) stale++;
        end
        chk("no_stale_result", stale, 0);
        post = '{16'h2222, 16'h3333, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        run_vec(post, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
